// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB arbiter slice.
// Provides the default bus widths, the arbiter FSM state type and the width
// of the ACCESS-phase wait counter (wide enough for any timeout up to 255).
package timer_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } arb_state_e;

endpackage

// File: rtl/timer_rr_arb2.sv
// Two-way round-robin pick.
//   req_i        : request vector, bit k = client k
//   last_grant_i : index of the client granted most recently
//   grant_o      : one-hot grant (all zero when nothing requests)
// On contention the client that was not granted last wins.
module timer_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/timer_apb_arb.sv
// Two-client APB master arbiter/sequencer in front of the timer APB slave.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   m0_* / m1_*      : client req/ack interfaces (req held until ack; ack,
//                      rdata and err are a one-cycle registered response)
//   tim_*            : APB master port towards the timer
// Clients are granted round-robin; each grant runs SETUP then ACCESS on the
// APB bus and returns data/error in a single RESP cycle. An ACCESS phase that
// sees no pready for TIMEOUT_CYC cycles is aborted and reported as an error.
module timer_apb_arb #(
    parameter int unsigned ADDR_W      = timer_pkg::ADDR_W,
    parameter int unsigned DATA_W      = timer_pkg::DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_strb,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_strb,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              tim_psel,
    output logic              tim_penable,
    output logic              tim_pwrite,
    output logic [ADDR_W-1:0] tim_paddr,
    output logic [DATA_W-1:0] tim_pwdata,
    output logic [3:0]        tim_pstrb,
    input  logic [DATA_W-1:0] tim_prdata,
    input  logic              tim_pready,
    input  logic              tim_pslverr
);

    import timer_pkg::*;

    arb_state_e        state_q;
    logic              last_grant_q;  // also identifies the client being served
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        grant;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_strb;
    logic [DATA_W-1:0] resp_rdata;

    timer_rr_arb2 u_arb (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        sel_write = grant[1] ? m1_write : m0_write;
        sel_addr  = grant[1] ? m1_addr  : m0_addr;
        sel_wdata = grant[1] ? m1_wdata : m0_wdata;
        sel_strb  = grant[1] ? m1_strb  : m0_strb;
        // Writes return zero data so a client never sees stale bus contents.
        resp_rdata = tim_pwrite ? '0 : tim_prdata;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            tim_psel     <= 1'b0;
            tim_penable  <= 1'b0;
            tim_pwrite   <= 1'b0;
            tim_paddr    <= '0;
            tim_pwdata   <= '0;
            tim_pstrb    <= '0;
            m0_ack       <= 1'b0;
            m0_rdata     <= '0;
            m0_err       <= 1'b0;
            m1_ack       <= 1'b0;
            m1_rdata     <= '0;
            m1_err       <= 1'b0;
        end else begin
            // Response outputs live for exactly one cycle.
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (|grant) begin
                        last_grant_q <= grant[1];
                        tim_pwrite   <= sel_write;
                        tim_paddr    <= sel_addr;
                        tim_pwdata   <= sel_wdata;
                        tim_pstrb    <= sel_write ? sel_strb : 4'b0000;
                        tim_psel     <= 1'b1;
                        tim_penable  <= 1'b0;
                        state_q      <= StSetup;
                    end
                end

                StSetup: begin
                    tim_penable <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= StAccess;
                end

                StAccess: begin
                    if (tim_pready) begin
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        state_q     <= StResp;
                        if (last_grant_q) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= resp_rdata;
                            m1_err   <= tim_pslverr;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= resp_rdata;
                            m0_err   <= tim_pslverr;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Slave never became ready: abort and flag an error.
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        state_q     <= StResp;
                        if (last_grant_q) begin
                            m1_ack <= 1'b1;
                            m1_err <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StResp: begin
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_apb_arb.sv
// Directed bench for timer_apb_arb: a table of single-client transactions
// with hand-computed bus/response expectations, plus hand-written sequences
// for contention/alternation and reset during an ACCESS phase.
module tb_timer_apb_arb;

    localparam int TO = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        tim_psel, tim_penable, tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata;
    logic        tim_pready, tim_pslverr;

    int n_vec = 0;
    int n_bad = 0;

    timer_apb_arb #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .m0_req      (m0_req),
        .m0_write    (m0_write),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_strb     (m0_strb),
        .m0_ack      (m0_ack),
        .m0_rdata    (m0_rdata),
        .m0_err      (m0_err),
        .m1_req      (m1_req),
        .m1_write    (m1_write),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_strb     (m1_strb),
        .m1_ack      (m1_ack),
        .m1_rdata    (m1_rdata),
        .m1_err      (m1_err),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          client;
        bit          write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;      // ACCESS cycles with pready low before it rises
        bit          slverr;
        logic [31:0] prdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;    // cycles from req sampling edge to ack
        int          exp_psel;   // cycles with psel high
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_client(input bit c, input bit req, input bit wr, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb);
        if (c) begin
            m1_req = req; m1_write = wr; m1_addr = addr; m1_wdata = wdata; m1_strb = strb;
        end else begin
            m0_req = req; m0_write = wr; m0_addr = addr; m0_wdata = wdata; m0_strb = strb;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus"}, {28'h0, tim_psel, tim_penable, tim_pwrite, 1'b0} | 32'(tim_pstrb), 0);
        chk({tag, "_paddr"}, 32'(tim_paddr), 0);
        chk({tag, "_pwdata"}, tim_pwdata, 0);
        chk({tag, "_resp"}, {28'h0, m0_ack, m0_err, m1_ack, m1_err}, 0);
        chk({tag, "_rdata"}, m0_rdata | m1_rdata, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  acc = 0;
        int  psel_cnt = 0;
        bit  done = 0;
        logic ack, other_ack;
        logic [31:0] rdata;
        logic err;
        set_client(v.client, 1'b1, v.write, v.addr, v.wdata, v.strb);
        tim_pready = 1'b0; tim_pslverr = 1'b0; tim_prdata = v.prdata;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge sys_clk); #1;
            if (tim_psel) begin
                psel_cnt++;
                chk($sformatf("v%0d_pstrb", idx), 32'(tim_pstrb), 32'(v.exp_strb));
            end
            if (tim_psel && !tim_penable) begin
                chk($sformatf("v%0d_paddr", idx), 32'(tim_paddr), 32'(v.addr));
                chk($sformatf("v%0d_pwrite", idx), 32'(tim_pwrite), 32'(v.write));
                if (v.write) chk($sformatf("v%0d_pwdata", idx), tim_pwdata, v.wdata);
            end
            if (tim_psel && tim_penable) begin
                tim_pready  = (acc >= v.waits);
                tim_pslverr = tim_pready & v.slverr;
                acc++;
            end else begin
                tim_pready  = 1'b0;
                tim_pslverr = 1'b0;
            end
            ack       = v.client ? m1_ack : m0_ack;
            other_ack = v.client ? m0_ack : m1_ack;
            rdata     = v.client ? m1_rdata : m0_rdata;
            err       = v.client ? m1_err : m0_err;
            if (ack) begin
                done = 1;
                chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(v.exp_lat));
                chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
                chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
                chk($sformatf("v%0d_other_ack", idx), 32'(other_ack), 0);
                chk($sformatf("v%0d_psel_cycles", idx), 32'(psel_cnt), 32'(v.exp_psel));
                chk($sformatf("v%0d_psel_in_resp", idx), 32'(tim_psel), 0);
                set_client(v.client, 1'b0, v.write, v.addr, v.wdata, v.strb);
            end
        end
        if (!done) begin
            chk($sformatf("v%0d_ack_seen", idx), 0, 1);
            set_client(v.client, 1'b0, v.write, v.addr, v.wdata, v.strb);
        end
        @(posedge sys_clk); #1;
        chk($sformatf("v%0d_after_ack", idx),
            {30'h0, (v.client ? m1_ack : m0_ack), (v.client ? m1_err : m0_err)}, 0);
        chk($sformatf("v%0d_after_rdata", idx), v.client ? m1_rdata : m0_rdata, 0);
    endtask

    // Both clients request together from a state where m0 should win. m0
    // re-requests as soon as it is acked, so m1 (still pending) must win the
    // next contention, then m0 again.
    task automatic contention(input string tag);
        logic [31:0] order[$];
        int          ack_cyc[$];
        int          acks = 0;
        bit          reissued = 0;
        tim_pready = 1'b1; tim_pslverr = 1'b0; tim_prdata = 32'h5A5A_0001;
        set_client(1'b0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        set_client(1'b1, 1'b1, 1'b0, 12'h200, 32'h0, 4'h0);
        for (int cyc = 1; cyc <= 30 && acks < 3; cyc++) begin
            @(posedge sys_clk); #1;
            if (tim_psel && !tim_penable) order.push_back(32'(tim_paddr));
            if (m0_ack) begin
                acks++;
                ack_cyc.push_back(cyc);
                if (!reissued) begin
                    reissued = 1;
                    chk({tag, "_m0_rdata"}, m0_rdata, 32'h5A5A_0001);
                    m0_addr = 12'h104;
                end else begin
                    m0_req = 1'b0;
                end
            end
            if (m1_ack) begin
                acks++;
                ack_cyc.push_back(cyc);
                m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk({tag, "_acks"}, 32'(acks), 3);
        chk({tag, "_grants"}, 32'(order.size()), 3);
        if (order.size() == 3) begin
            chk({tag, "_first"}, order[0], 32'h100);
            chk({tag, "_second"}, order[1], 32'h200);
            chk({tag, "_third"}, order[2], 32'h104);
        end
        if (ack_cyc.size() == 3) begin
            chk({tag, "_ack_cyc0"}, 32'(ack_cyc[0]), 3);
            chk({tag, "_ack_cyc1"}, 32'(ack_cyc[1]), 7);
            chk({tag, "_ack_cyc2"}, 32'(ack_cyc[2]), 11);
        end
        tim_pready = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        //            cl wr addr     wdata          strb waits err prdata         estrb erdata         eerr lat psel
        vecs[0] = '{1'b0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0,  1'b0, 32'hAAAA5555, 4'hF, 32'h0,        1'b0, 3,  2};
        vecs[1] = '{1'b1, 1'b0, 12'h010, 32'h0,        4'hF, 3,  1'b0, 32'h12345678, 4'h0, 32'h12345678, 1'b0, 6,  5};
        vecs[2] = '{1'b0, 1'b0, 12'h008, 32'h0,        4'h0, 0,  1'b1, 32'hCAFEF00D, 4'h0, 32'hCAFEF00D, 1'b1, 3,  2};
        vecs[3] = '{1'b1, 1'b1, 12'hFFC, 32'h0BADF00D, 4'h5, 1,  1'b1, 32'h99999999, 4'h5, 32'h0,        1'b1, 4,  3};
        vecs[4] = '{1'b0, 1'b0, 12'h020, 32'h0,        4'h0, 20, 1'b0, 32'h11111111, 4'h0, 32'h0,        1'b1, 18, 17};
        vecs[5] = '{1'b1, 1'b0, 12'h000, 32'h0,        4'h0, 15, 1'b0, 32'h87654321, 4'h0, 32'h87654321, 1'b0, 18, 17};

        sys_rst = 1'b1;
        set_client(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        set_client(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        tim_prdata = 32'h0; tim_pready = 1'b0; tim_pslverr = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_all_zero("reset");
        sys_rst = 1'b0;

        contention("cont");

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Leave last_grant at m0 so that only a working reset lets m0 win below.
        run_vec(0, vecs[0]);

        // Start an m0 transfer, stall it in ACCESS, then reset.
        tim_pready = 1'b0;
        set_client(1'b0, 1'b1, 1'b1, 12'h0AB, 32'h0000_0077, 4'h3);
        begin
            bit in_access = 0;
            for (int cyc = 0; cyc < 10 && !in_access; cyc++) begin
                @(posedge sys_clk); #1;
                in_access = tim_psel && tim_penable;
            end
            chk("rst_reached_access", 32'(in_access), 1);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        m0_req  = 1'b0;
        @(posedge sys_clk); #1;
        chk_all_zero("rst_mid");
        sys_rst = 1'b0;
        begin
            int stray = 0;
            repeat (4) begin
                @(posedge sys_clk); #1;
                stray += int'(m0_ack) + int'(m1_ack) + int'(tim_psel);
            end
            chk("rst_no_ack", 32'(stray), 0);
        end

        contention("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
